// File: rtl/bullet_collider_pkg.sv
// Shared game constants: pool sizes, sprite boxes, 20-bit slot layout and FSM states.
// Bullet pool, enemy logic and the collider all pull geometry from here.
package bullet_collider_pkg;

    localparam int NUM_BULLETS = 30;
    localparam int NUM_ENEMIES = 8;

    localparam int BULLET_W = 4;
    localparam int BULLET_H = 10;
    localparam int ENEMY_W  = 26;
    localparam int ENEMY_H  = 20;

    // Slot layout: x in [19:10], y in [9:0]
    localparam int COORD_W = 10;
    localparam int SLOT_W  = 2 * COORD_W;
    localparam int X_LSB   = COORD_W;
    localparam int Y_LSB   = 0;

    localparam logic [COORD_W-1:0] INACTIVE_X = 10'h3FF;

    localparam int HIT_CNT_W = 6;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic logic slot_active(input slot_t s);
        return s.x != INACTIVE_X;
    endfunction

endpackage

// File: rtl/bullet_collider_if.sv
// Frame-scan handshake between the game controller and the collider.
// master drives positions and frame_tick; slave returns per-scan hit pulses.
interface bullet_collider_if
    import bullet_collider_pkg::*;
#(
    parameter int NB = NUM_BULLETS,
    parameter int NE = NUM_ENEMIES
) ();

    logic                 frame_tick;
    logic [SLOT_W*NB-1:0] bullet_pos;
    logic [SLOT_W*NE-1:0] enemy_pos;
    logic [NE-1:0]        enemy_alive;
    logic [NB-1:0]        collided;
    logic [NE-1:0]        enemy_hit;
    logic [HIT_CNT_W-1:0] hit_count;
    logic                 busy;
    logic                 done;

    modport master (
        output frame_tick, bullet_pos, enemy_pos, enemy_alive,
        input  collided, enemy_hit, hit_count, busy, done
    );

    modport slave (
        input  frame_tick, bullet_pos, enemy_pos, enemy_alive,
        output collided, enemy_hit, hit_count, busy, done
    );

endinterface

// File: rtl/bullet_collider_box_overlap.sv
// Combinational axis-aligned box overlap test between box A and box B.
// Sums are widened by one bit so boxes near the right/bottom edge never wrap.
module box_overlap
    import bullet_collider_pkg::*;
#(
    parameter int A_W = BULLET_W,
    parameter int A_H = BULLET_H,
    parameter int B_W = ENEMY_W,
    parameter int B_H = ENEMY_H
) (
    input  coord_t ax,
    input  coord_t ay,
    input  coord_t bx,
    input  coord_t by,
    output logic   hit
);

    localparam int EW = COORD_W + 1;

    logic [EW-1:0] ax_e, ay_e, bx_e, by_e;

    assign ax_e = {1'b0, ax};
    assign ay_e = {1'b0, ay};
    assign bx_e = {1'b0, bx};
    assign by_e = {1'b0, by};

    assign hit = (ax_e < bx_e + EW'(B_W)) &&
                 (bx_e < ax_e + EW'(A_W)) &&
                 (ay_e < by_e + EW'(B_H)) &&
                 (by_e < ay_e + EW'(A_H));

endmodule

// File: rtl/bullet_collider.sv
// Per-frame bullet vs enemy collision scanner: snapshots positions on frame_tick,
// walks one (bullet, enemy) pair per cycle, then reports all hits in a single cycle.
module bullet_collider #(
    parameter int NUM_BULLETS = bullet_collider_pkg::NUM_BULLETS,
    parameter int NUM_ENEMIES = bullet_collider_pkg::NUM_ENEMIES,
    parameter int BULLET_W    = bullet_collider_pkg::BULLET_W,
    parameter int BULLET_H    = bullet_collider_pkg::BULLET_H,
    parameter int ENEMY_W     = bullet_collider_pkg::ENEMY_W,
    parameter int ENEMY_H     = bullet_collider_pkg::ENEMY_H
) (
    input  logic              clock,
    input  logic              reset,
    bullet_collider_if.slave  bus
);
    import bullet_collider_pkg::*;

    localparam int IW = $clog2(NUM_BULLETS);
    localparam int JW = $clog2(NUM_ENEMIES);

    state_t                       state_q, state_d;
    logic [IW-1:0]                i_q, i_d;
    logic [JW-1:0]                j_q, j_d;
    logic [NUM_BULLETS-1:0]       pend_b_q, pend_b_d;
    logic [NUM_ENEMIES-1:0]       pend_e_q, pend_e_d;
    logic [HIT_CNT_W-1:0]         cnt_q, cnt_d;
    logic [HIT_CNT_W-1:0]         hit_count_q;

    slot_t [NUM_BULLETS-1:0]      snap_b;
    slot_t [NUM_ENEMIES-1:0]      snap_e;
    logic  [NUM_ENEMIES-1:0]      snap_alive;

    slot_t cur_b, cur_e;
    logic  b_active, overlap, pair_hit, last_i, last_j, adv;

    assign cur_b    = snap_b[i_q];
    assign cur_e    = snap_e[j_q];
    assign b_active = slot_active(cur_b);
    assign last_i   = (i_q == IW'(NUM_BULLETS - 1));
    assign last_j   = (j_q == JW'(NUM_ENEMIES - 1));

    box_overlap #(
        .A_W(BULLET_W), .A_H(BULLET_H),
        .B_W(ENEMY_W),  .B_H(ENEMY_H)
    ) u_overlap (
        .ax (cur_b.x),
        .ay (cur_b.y),
        .bx (cur_e.x),
        .by (cur_e.y),
        .hit(overlap)
    );

    // An enemy already claimed this scan is invisible to later bullets
    assign pair_hit = b_active && overlap && snap_alive[j_q] && !pend_e_q[j_q];

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        pend_b_d = pend_b_q;
        pend_e_d = pend_e_q;
        cnt_d    = cnt_q;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    state_d  = SCAN;
                    i_d      = '0;
                    j_d      = '0;
                    pend_b_d = '0;
                    pend_e_d = '0;
                    cnt_d    = '0;
                end
            end
            SCAN: begin
                if (!b_active) begin
                    adv = 1'b1;
                end else if (pair_hit) begin
                    pend_b_d[i_q] = 1'b1;
                    pend_e_d[j_q] = 1'b1;
                    cnt_d         = cnt_q + HIT_CNT_W'(1);
                    adv           = 1'b1;
                end else if (last_j) begin
                    adv = 1'b1;
                end else begin
                    j_d = j_q + JW'(1);
                end
                if (adv) begin
                    j_d = '0;
                    if (last_i) state_d = REPORT;
                    else        i_d     = i_q + IW'(1);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            pend_b_q    <= '0;
            pend_e_q    <= '0;
            cnt_q       <= '0;
            hit_count_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            pend_b_q <= pend_b_d;
            pend_e_q <= pend_e_d;
            cnt_q    <= cnt_d;
            // Load on entry to REPORT so the count is valid alongside done
            if (state_q == SCAN && state_d == REPORT)
                hit_count_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state_q == IDLE && bus.frame_tick) begin
            snap_b     <= bus.bullet_pos;
            snap_e     <= bus.enemy_pos;
            snap_alive <= bus.enemy_alive;
        end
    end

    assign bus.collided  = (state_q == REPORT) ? pend_b_q : '0;
    assign bus.enemy_hit = (state_q == REPORT) ? pend_e_q : '0;
    assign bus.done      = (state_q == REPORT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.hit_count = hit_count_q;

endmodule

// File: tb/tb_bullet_collider.sv
// Bench for bullet_collider: directed geometry table, worst-case/reset sequences,
// and randomized scenes against a frame-level reference model.
module tb_bullet_collider;
    import bullet_collider_pkg::*;

    localparam int NB = NUM_BULLETS;
    localparam int NE = NUM_ENEMIES;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bullet_collider_if bus ();

    bullet_collider dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int b0, b0x, b0y;
        int b1, b1x, b1y;
        int e, ex, ey;
        logic [NE-1:0] alive;
        logic [NB-1:0] col;
        logic [NE-1:0] en;
        int cnt;
        int lat;
    } vec_t;

    localparam int NV = 10;
    vec_t  vecs [NV];
    string names[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] slot(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    function automatic logic [20*NB-1:0] mk_bullets(input int b0, b0x, b0y, b1, b1x, b1y);
        logic [20*NB-1:0] r;
        for (int i = 0; i < NB; i++) r[20*i +: 20] = {10'h3FF, 10'd0};
        if (b0 >= 0) r[20*b0 +: 20] = slot(b0x, b0y);
        if (b1 >= 0) r[20*b1 +: 20] = slot(b1x, b1y);
        return r;
    endfunction

    function automatic logic [20*NE-1:0] mk_enemies(input int e, ex, ey);
        logic [20*NE-1:0] r;
        r = '0;
        if (e >= 0) r[20*e +: 20] = slot(ex, ey);
        return r;
    endfunction

    // Frame-level model: bullets in order, each claims the lowest free overlapping enemy.
    // Latency counts the tick cycle, one cycle per pair tried, and the report cycle.
    function automatic void model(input logic [20*NB-1:0] bp, input logic [20*NE-1:0] ep,
                                  input logic [NE-1:0] al,
                                  output logic [NB-1:0] col, output logic [NE-1:0] en,
                                  output int cnt, output int lat);
        int bx, by, ex, ey;
        bit done_b;
        col = '0; en = '0; cnt = 0; lat = 2;
        for (int b = 0; b < NB; b++) begin
            bx = int'(bp[20*b+10 +: 10]);
            by = int'(bp[20*b +: 10]);
            if (bx == 1023) begin
                lat++;
            end else begin
                done_b = 1'b0;
                for (int e = 0; e < NE; e++) begin
                    if (!done_b) begin
                        ex = int'(ep[20*e+10 +: 10]);
                        ey = int'(ep[20*e +: 10]);
                        lat++;
                        if (al[e] && !en[e] && bx < ex + ENEMY_W && ex < bx + BULLET_W &&
                            by < ey + ENEMY_H && ey < by + BULLET_H) begin
                            col[b] = 1'b1;
                            en[e]  = 1'b1;
                            cnt++;
                            done_b = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic run_scan(input logic [20*NB-1:0] bp, input logic [20*NE-1:0] ep,
                            input logic [NE-1:0] al, input bit disturb,
                            output logic [NB-1:0] col, output logic [NE-1:0] en,
                            output logic [5:0] hc, output int lat,
                            output logic after_pulse, output logic [5:0] hc_after,
                            output logic busy_seen);
        bit fin;
        @(negedge clock);
        bus.bullet_pos  = bp;
        bus.enemy_pos   = ep;
        bus.enemy_alive = al;
        bus.frame_tick  = 1'b1;
        lat = 1; busy_seen = 1'b0; fin = 1'b0;
        while (!fin) begin
            @(posedge clock); #1;
            bus.frame_tick = 1'b0;
            lat++;
            if (lat == 2) busy_seen = bus.busy;
            if (bus.done) fin = 1'b1;
            else if (lat >= 300) begin lat = -1; fin = 1'b1; end
            else if (disturb && lat == 5) begin
                for (int k = 0; k < NE; k++) bus.enemy_pos[20*k +: 20] = 20'($urandom);
                for (int k = 0; k < NB; k++) bus.bullet_pos[20*k +: 20] = 20'($urandom);
                bus.enemy_alive = ~al;
                bus.frame_tick  = 1'b1;
            end
        end
        col = bus.collided;
        en  = bus.enemy_hit;
        hc  = bus.hit_count;
        @(posedge clock); #1;
        after_pulse = bus.done | (|bus.collided) | (|bus.enemy_hit);
        hc_after    = bus.hit_count;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [20*NB-1:0] bp;
        logic [20*NE-1:0] ep;
        logic [NE-1:0]    al;
        logic [NB-1:0]    col, m_col;
        logic [NE-1:0]    en, m_en;
        logic [5:0]       hc, hc_after;
        logic             after_pulse, busy_seen;
        int               lat, m_cnt, m_lat, seen, base;

        //          b0  x    y    b1  x    y    e  ex   ey  alive  col     en    cnt lat
        vecs[0] = '{0, 100, 100, -1, 0,   0,   0, 90,  95, 8'h01, 30'h1,  8'h01, 1, 32}; names[0] = "basic_hit";
        vecs[1] = '{0, 116, 100, -1, 0,   0,   0, 90,  95, 8'h01, 30'h0,  8'h00, 0, 39}; names[1] = "right_edge_miss";
        vecs[2] = '{0, 115, 100, -1, 0,   0,   0, 90,  95, 8'h01, 30'h1,  8'h01, 1, 32}; names[2] = "right_edge_hit";
        vecs[3] = '{0, 100, 115, -1, 0,   0,   0, 90,  95, 8'h01, 30'h0,  8'h00, 0, 39}; names[3] = "bottom_edge_miss";
        vecs[4] = '{0, 100, 114, -1, 0,   0,   0, 90,  95, 8'h01, 30'h1,  8'h01, 1, 32}; names[4] = "bottom_edge_hit";
        vecs[5] = '{0, 100, 85,  -1, 0,   0,   0, 90,  95, 8'h01, 30'h0,  8'h00, 0, 39}; names[5] = "top_edge_miss";
        vecs[6] = '{0, 86,  100, -1, 0,   0,   0, 90,  95, 8'h01, 30'h0,  8'h00, 0, 39}; names[6] = "left_edge_miss";
        vecs[7] = '{3, 205, 205, 7,  210, 210, 2, 200, 200, 8'h04, 30'h8, 8'h04, 1, 41}; names[7] = "first_bullet_wins";
        vecs[8] = '{0, 100, 100, -1, 0,   0,   0, 90,  95, 8'h00, 30'h0,  8'h00, 0, 39}; names[8] = "dead_enemy";
        vecs[9] = '{-1, 0,  0,   -1, 0,   0,   0, 90,  95, 8'hFF, 30'h0,  8'h00, 0, 32}; names[9] = "all_inactive";

        reset           = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.bullet_pos  = mk_bullets(-1, 0, 0, -1, 0, 0);
        bus.enemy_pos   = '0;
        bus.enemy_alive = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_collided", 64'(bus.collided), 64'd0);
        check("rst_enemy_hit", 64'(bus.enemy_hit), 64'd0);
        check("rst_hit_count", 64'(bus.hit_count), 64'd0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            bp = mk_bullets(vecs[v].b0, vecs[v].b0x, vecs[v].b0y, vecs[v].b1, vecs[v].b1x, vecs[v].b1y);
            ep = mk_enemies(vecs[v].e, vecs[v].ex, vecs[v].ey);
            run_scan(bp, ep, vecs[v].alive, 1'b0, col, en, hc, lat, after_pulse, hc_after, busy_seen);
            check({names[v], "_collided"}, 64'(col), 64'(vecs[v].col));
            check({names[v], "_enemy_hit"}, 64'(en), 64'(vecs[v].en));
            check({names[v], "_hit_count"}, 64'(hc), 64'(vecs[v].cnt));
            check({names[v], "_latency"}, 64'(lat), 64'(vecs[v].lat));
            check({names[v], "_busy"}, 64'(busy_seen), 64'd1);
            check({names[v], "_single_pulse"}, 64'(after_pulse), 64'd0);
            check({names[v], "_count_held"}, 64'(hc_after), 64'(vecs[v].cnt));
        end

        // Every bullet active, every enemy alive, nothing overlaps
        bp = '0;
        for (int k = 0; k < NB; k++) bp[20*k +: 20] = slot(500, 500);
        ep = '0;
        al = '1;
        run_scan(bp, ep, al, 1'b1, col, en, hc, lat, after_pulse, hc_after, busy_seen);
        check("worst_latency", 64'(lat), 64'd242);
        check("worst_collided", 64'(col), 64'd0);
        check("worst_hit_count", 64'(hc), 64'd0);

        // Reset partway through a long scan
        @(negedge clock);
        bus.bullet_pos = bp; bus.enemy_pos = ep; bus.enemy_alive = al;
        bus.frame_tick = 1'b1;
        @(negedge clock);
        bus.frame_tick = 1'b0;
        repeat (48) @(negedge clock);
        check("busy_mid_scan", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("busy_after_reset", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (260) begin
            @(negedge clock);
            if (bus.done || (|bus.collided) || (|bus.enemy_hit)) seen++;
        end
        check("no_pulse_after_abort", 64'(seen), 64'd0);

        // Tick coinciding with reset must not start a scan
        @(negedge clock);
        reset = 1'b1; bus.frame_tick = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus.frame_tick = 1'b0;
        @(negedge clock);
        check("tick_with_reset", 64'(bus.busy), 64'd0);

        bp = mk_bullets(0, 100, 100, -1, 0, 0);
        ep = mk_enemies(0, 90, 95);
        run_scan(bp, ep, 8'h01, 1'b0, col, en, hc, lat, after_pulse, hc_after, busy_seen);
        check("post_reset_collided", 64'(col), 64'd1);
        check("post_reset_hit_count", 64'(hc), 64'd1);
        check("post_reset_latency", 64'(lat), 64'd32);

        // Random scenes, half disturbed mid-scan; some placed near the coordinate ceiling
        for (int it = 0; it < 40; it++) begin
            base = ($urandom_range(0, 3) == 0) ? 900 : 0;
            for (int k = 0; k < NE; k++)
                ep[20*k +: 20] = slot(base + $urandom_range(0, 122), base + $urandom_range(0, 122));
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(0, 3) == 0) bp[20*k +: 20] = {10'h3FF, 10'($urandom)};
                else bp[20*k +: 20] = slot(base + $urandom_range(0, 122), base + $urandom_range(0, 122));
            end
            al = NE'($urandom);
            model(bp, ep, al, m_col, m_en, m_cnt, m_lat);
            run_scan(bp, ep, al, it[0], col, en, hc, lat, after_pulse, hc_after, busy_seen);
            check("rand_collided", 64'(col), 64'(m_col));
            check("rand_enemy_hit", 64'(en), 64'(m_en));
            check("rand_hit_count", 64'(hc), 64'(m_cnt));
            check("rand_latency", 64'(lat), 64'(m_lat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
